// File: rtl/huff_pkg.sv
// Shared constants and types for the Huffman digit path (encoder, code builder, decoder).
package huff_pkg;

    localparam int         NSYM   = 10;
    localparam int         MAXLEN = 9;
    localparam logic [3:0] TERM   = 4'hF;

    typedef logic [MAXLEN-1:0] code_t;
    typedef logic [3:0]        len_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_e;

    // Mask selecting the low 'len' bits of a right-aligned code.
    function automatic code_t len_mask(input len_t len);
        code_t m;
        m = '0;
        for (int i = 0; i < MAXLEN; i++) begin
            m[i] = (len > len_t'(i));
        end
        return m;
    endfunction

endpackage

// File: rtl/huff_match.sv
// Combinational table lookup: finds the lowest-index entry whose code equals the
// bits accumulated so far at exactly the current length.
module huff_match
    import huff_pkg::*;
(
    input  code_t      tbl_code [NSYM],
    input  len_t       tbl_len  [NSYM],
    input  code_t      n_acc,
    input  len_t       n_len,
    output logic       hit,
    output logic [3:0] sym
);

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        hit = 1'b0;
        sym = 4'd0;
        for (int i = NSYM - 1; i >= 0; i--) begin
            if ((tbl_len[i] != 4'd0) && (tbl_len[i] == n_len) &&
                ((tbl_code[i] & len_mask(n_len)) == n_acc)) begin
                hit = 1'b1;
                sym = 4'(i);
            end
        end
    end

endmodule

// File: rtl/huff_decode.sv
// Serial Huffman decoder: MSB-first bits in, 4-bit digits out, terminated by TERM
// once the requested number of symbols has been decoded.
//
// state | meaning
// ------+-------------------------------------------------------------------
// IDLE  | after reset; table writable, waiting for Start
// RUN   | consuming bits; term_pend_q marks the one-cycle terminator drain
// DONE  | all symbols plus terminator emitted; table writable, Start restarts
// ERR   | no code matched within MAXLEN bits; table writable, Start restarts
module huff_decode
    import huff_pkg::*;
(
    input  logic       Clk_in,
    input  logic       nRst,
    input  logic       Start,
    input  logic [8:0] Sym_total,
    input  logic       Tbl_we,
    input  logic [3:0] Tbl_sym,
    input  logic [8:0] Tbl_code,
    input  logic [3:0] Tbl_len,
    input  logic       Bit_in,
    input  logic       Bit_valid,
    output logic       Bit_ready,
    output logic [3:0] Data_out,
    output logic       Data_valid,
    output logic [8:0] Dec_cnt,
    output logic       Busy,
    output logic       Done,
    output logic       Err
);

    code_t      tbl_code_q [NSYM];
    len_t       tbl_len_q  [NSYM];

    state_e     state_q,      state_d;
    code_t      acc_q,        acc_d;
    len_t       len_q,        len_d;
    logic [8:0] total_q,      total_d;
    logic [8:0] dec_cnt_q,    dec_cnt_d;
    logic       term_pend_q,  term_pend_d;
    logic [3:0] data_out_q,   data_out_d;
    logic       data_valid_q, data_valid_d;
    logic       busy_q,       busy_d;
    logic       bit_ready_q,  bit_ready_d;
    logic       done_q,       done_d;
    logic       err_q,        err_d;

    logic       tbl_wr;
    code_t      n_acc;
    len_t       n_len;
    logic       hit;
    logic [3:0] hit_sym;

    // The table is frozen while decoding; out-of-range indices are dropped.
    assign tbl_wr = Tbl_we && (state_q != RUN) && (Tbl_sym < 4'(NSYM));

    // Candidate accumulator/length if the offered bit were consumed this cycle.
    assign n_acc = (acc_q << 1) | code_t'(Bit_in);
    assign n_len = len_q + 4'd1;

    huff_match u_match (
        .tbl_code (tbl_code_q),
        .tbl_len  (tbl_len_q),
        .n_acc    (n_acc),
        .n_len    (n_len),
        .hit      (hit),
        .sym      (hit_sym)
    );

    // Code table storage; only reset clears it so it survives restarts.
    always_ff @(posedge Clk_in or negedge nRst) begin
        if (!nRst) begin
            for (int i = 0; i < NSYM; i++) begin
                tbl_code_q[i] <= '0;
                tbl_len_q[i]  <= '0;
            end
        end else if (tbl_wr) begin
            tbl_code_q[Tbl_sym] <= Tbl_code;
            tbl_len_q[Tbl_sym]  <= Tbl_len;
        end
    end

    // Next-state and next-output computation for the decode FSM.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        len_d        = len_q;
        total_d      = total_q;
        dec_cnt_d    = dec_cnt_q;
        term_pend_d  = term_pend_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        done_d       = done_q;
        err_d        = err_q;

        case (state_q)
            RUN: begin
                if (term_pend_q) begin
                    // Last symbol went out last cycle; emit the terminator and stop.
                    term_pend_d  = 1'b0;
                    state_d      = DONE;
                    done_d       = 1'b1;
                    data_out_d   = TERM;
                    data_valid_d = 1'b1;
                end else if (Bit_valid) begin
                    if (hit) begin
                        data_out_d   = hit_sym;
                        data_valid_d = 1'b1;
                        dec_cnt_d    = dec_cnt_q + 9'd1;
                        acc_d        = '0;
                        len_d        = '0;
                        if ((dec_cnt_q + 9'd1) == total_q) begin
                            term_pend_d = 1'b1;
                        end
                    end else if (n_len == len_t'(MAXLEN)) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        acc_d = n_acc;
                        len_d = n_len;
                    end
                end
            end
            default: begin
                if (Start) begin
                    total_d     = Sym_total;
                    acc_d       = '0;
                    len_d       = '0;
                    dec_cnt_d   = '0;
                    done_d      = 1'b0;
                    err_d       = 1'b0;
                    term_pend_d = 1'b0;
                    if (Sym_total == 9'd0) begin
                        state_d      = DONE;
                        done_d       = 1'b1;
                        data_out_d   = TERM;
                        data_valid_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
        endcase

        busy_d      = (state_d == RUN);
        bit_ready_d = (state_d == RUN);
    end

    // Register FSM state, datapath and all outputs together.
    always_ff @(posedge Clk_in or negedge nRst) begin
        if (!nRst) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            len_q        <= '0;
            total_q      <= '0;
            dec_cnt_q    <= '0;
            term_pend_q  <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            bit_ready_q  <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            len_q        <= len_d;
            total_q      <= total_d;
            dec_cnt_q    <= dec_cnt_d;
            term_pend_q  <= term_pend_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            busy_q       <= busy_d;
            bit_ready_q  <= bit_ready_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign Bit_ready  = bit_ready_q;
    assign Data_out   = data_out_q;
    assign Data_valid = data_valid_q;
    assign Dec_cnt    = dec_cnt_q;
    assign Busy       = busy_q;
    assign Done       = done_q;
    assign Err        = err_q;

endmodule

// File: doc/huff_decode.md
# huff_decode

Huffman bitstream decoder for the 10-symbol (digits 0–9) compression path. It decodes an MSB-first serial bitstream back into 4-bit digits using a code table written by the host or the code-builder stage. After the programmed number of symbols, it emits the stream terminator 4'hF. Its output has the same Data/terminator form as the frequency-counting front end, so decoded streams can be looped back for checking.

## Interface
Parameters:
- NSYM, 10, number of symbols (table entries)
- MAXLEN, 9, maximum code length in bits (NSYM-1)

Ports:
- Clk_in  input  1  clock. All logic updates on the rising edge.
- nRst  input  1  reset. Asynchronous, active-low.
- Start  input  1  level, sampled on rising edge. IDLE/DONE/ERR -> RUN.
- Sym_total  input  9  number of symbols to decode, 0..256. Sampled when Start is accepted.
- Tbl_we  input  1  table write strobe. Honoured only in IDLE/DONE/ERR.
- Tbl_sym  input  4  table entry index, 0..9. Writes with values >9 are ignored.
- Tbl_code  input  9  code, right-aligned.
- Tbl_len  input  4  code length, 1..9. A length of 0 marks the entry unused.
- Bit_in  input  1  next code bit, MSB of each code first.
- Bit_valid  input  1  Bit_in qualifier.
- Bit_ready  output  1  decoder accepts a bit. Equal to (state==RUN).
- Data_out  output  4  decoded digit, or 4'hF as terminator.
- Data_valid  output  1  Data_out qualifier, one-cycle pulse per symbol.
- Dec_cnt  output  9  symbols decoded since the last Start.
- Busy  output  1  state==RUN.
- Done  output  1  sticky. Set when all symbols are decoded.
- Err  output  1  sticky. Set when no code matches within MAXLEN bits.

## Operation
- States are IDLE, RUN, DONE and ERR.
- Reset:
  - state = IDLE.
  - All outputs are 0: Data_out=0, Data_valid=0, Dec_cnt=0, Done=0, Err=0.
  - Shift accumulator Acc[8:0]=0 and length Len=0.
  - All table lengths are 0. The table is cleared only by reset.
- IDLE/DONE/ERR with Start=1:
  - Latch Sym_total.
  - Clear Acc, Len, Dec_cnt, Done and Err.
  - Go to RUN. If the latched Sym_total==0, go to DONE instead and emit the terminator.
- RUN, handshake Bit_valid & Bit_ready:
  - Form nAcc = {Acc[7:0], Bit_in} and nLen = Len+1.
  - An entry i matches when Tbl_len[i]==nLen and the low nLen bits of Tbl_code[i] equal nAcc.
  - Match: Data_out=i, Data_valid=1, Dec_cnt+1, Acc=0, Len=0. If several entries match, the lowest index wins.
  - No match with nLen<MAXLEN: Acc=nAcc, Len=nLen.
  - No match with nLen==MAXLEN: go to ERR, Err=1, no Data_valid.
- Reaching Sym_total: when Dec_cnt+1 equals the latched Sym_total on a match:
  - The next cycle emits Data_out=4'hF with Data_valid=1.
  - Done=1 and state goes to DONE.
  - Bit_ready falls in the same cycle the terminator is emitted.
- Bits presented while Bit_ready=0 are not consumed. Upstream must hold them.
- Tbl_we in RUN is ignored, so the table stays stable during a decode.
- Start is ignored while in RUN.
- Width rule: Dec_cnt is 9 bits, and Sym_total=256 is legal with no wrap.

## Timing
- Bit-to-symbol latency: a bit accepted at edge n that completes a code gives Data_valid=1 and Data_out valid after edge n.
- Throughput: one bit per cycle. Symbols arrive back-to-back with no bubble.
- Terminator: Data_valid is high after the edge following the last symbol's edge. It lasts one cycle.
- Done, Err, Busy and Bit_ready are registered and change on the same edge as the state.
- Start accepted at edge n gives Busy=1 and Bit_ready=1 after edge n.
- Table write at edge n can be used by a Start accepted at edge n+1.
- nRst asserted mid-RUN aborts immediately to the reset values. No terminator is emitted.

## Structure
- Package huff_pkg holds:
  - NSYM=10, MAXLEN=9.
  - TERM=4'hF.
  - The state enum {IDLE, RUN, DONE, ERR}.
  - Typedefs for code (9-bit) and length (4-bit).
  - This package is shared with the encoder and the code-builder stage.
- Sub-module huff_match is purely combinational.
  - Inputs: table arrays, nAcc, nLen.
  - Outputs: hit, sym[3:0], with lowest-index priority.
- The table registers, FSM, accumulator and counters live in huff_decode.

## Test plan
- Length and code notation: a "len2 '00'" entry below means Tbl_len=2, Tbl_code=2'b00.
- Basic decode.
  - Table: 0=len2 '00', 1=len2 '01', 2=len2 '10', 3=len3 '110', 4=len3 '111'; Sym_total=5.
  - Stimulus: bits 00 01 10 110 111.
  - Expected: digits 0,1,2,3,4, then 4'hF. Dec_cnt=5, Done=1.
- Max length.
  - Table: unary code for 0..8 ('1','01',…), with 9='000000000'; Sym_total=2.
  - Stimulus: nine 0s, then '1'.
  - Expected: digits 9 then 0, then terminator.
- Error.
  - Table: only 0=len1 '1'; Sym_total=3.
  - Stimulus: nine 0s.
  - Expected: Err=1 after the 9th bit, no Data_valid, Bit_ready=0.
- Backpressure and gaps.
  - Stimulus: random Bit_valid gaps in the basic decode case, and Bit_valid held after Done.
  - Expected: same output digits. Bits are not consumed after the terminator.
- Control corners.
  - Sym_total=0: immediate terminator and Done.
  - Tbl_we during RUN: ignored.
  - nRst mid-decode: all outputs return to 0.
  - Restart from DONE: Dec_cnt clears and the table is retained.
